// File: rtl/shift_sequencer_if.sv
// Request/response and shift-register control bundle for shift_sequencer.
// The requester drives start/abort/tx_data; the sequencer drives everything else.
interface shift_sequencer_if #(
    parameter int W = 8
);
    logic         start;
    logic         abort;
    logic [W-1:0] tx_data;
    logic [W-1:0] sr_pdata;
    logic         sr_load;
    logic         sr_shift;
    logic         sclk;
    logic         cs_n;
    logic         busy;
    logic         done;

    modport master (
        output start, abort, tx_data,
        input  sr_pdata, sr_load, sr_shift, sclk, cs_n, busy, done
    );

    modport slave (
        input  start, abort, tx_data,
        output sr_pdata, sr_load, sr_shift, sclk, cs_n, busy, done
    );
endinterface

// File: rtl/shift_sequencer.sv
// Loads a word into the board shift register, then clocks it out serially,
// one bit every DIV clk cycles, framed by cs_n and reported via busy/done.
module shift_sequencer #(
    parameter int W   = 8,
    parameter int DIV = 4
) (
    input  logic              clk,
    input  logic              reset,
    shift_sequencer_if.slave  bus
);
    localparam int DIV_W = $clog2(DIV);
    localparam int BIT_W = $clog2(W + 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
    localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(DIV / 2);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(W - 1);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SHIFT,
        DONE
    } state_t;

    state_t           state, next_state;
    logic [DIV_W-1:0] div_cnt, div_next;
    logic [BIT_W-1:0] bit_cnt, bit_next;
    logic [W-1:0]     pdata;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            div_cnt <= '0;
            bit_cnt <= '0;
        end else begin
            state   <= next_state;
            div_cnt <= div_next;
            bit_cnt <= bit_next;
        end
    end

    // Counters only advance while staying in SHIFT; any other path clears them.
    always_comb begin
        next_state = state;
        div_next   = '0;
        bit_next   = '0;
        case (state)
            IDLE: begin
                if (bus.start) next_state = LOAD;
            end
            LOAD: begin
                next_state = bus.abort ? IDLE : SHIFT;
            end
            SHIFT: begin
                if (bus.abort) begin
                    next_state = IDLE;
                end else if (div_cnt == DIV_LAST) begin
                    if (bit_cnt == BIT_LAST) begin
                        next_state = DONE;
                    end else begin
                        bit_next = bit_cnt + BIT_W'(1);
                    end
                end else begin
                    div_next = div_cnt + DIV_W'(1);
                    bit_next = bit_cnt;
                end
            end
            DONE: begin
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pdata <= '0;
        end else if (state == IDLE && bus.start) begin
            pdata <= bus.tx_data;
        end
    end

    // Outputs decode straight from state/counters so reset clears them at once.
    assign bus.sr_pdata = pdata;
    assign bus.sr_load  = (state == LOAD);
    assign bus.sr_shift = (state == SHIFT) && (div_cnt == DIV_LAST);
    assign bus.sclk     = (state == SHIFT) && (div_cnt >= DIV_HALF);
    assign bus.busy     = (state == LOAD) || (state == SHIFT);
    assign bus.cs_n     = !((state == LOAD) || (state == SHIFT));
    assign bus.done     = (state == DONE);
endmodule
